wb_dma_sequencer: RTL and testbench

Word-copy engine that sits directly upstream of wb_master_interface and drives its start/address/selection/write/data_wr command port. It copies a block of 32-bit words from a source to a destination address, one read then one write per word. Each transaction completes on the master's `active` handshake, and each transaction is guarded by a timeout. It is the data-movement front end for the DAQ master port, for example RAM0 to RAM1 transfers across the bus matrix.

---
 rtl/wb_dma_pkg.sv | 30 +++
 rtl/wb_dma_timeout.sv | 37 +++
 rtl/wb_dma_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_wb_dma_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_dma_pkg
//  Description : Shared state encoding and constants for the word-copy
//                sequencer that drives the wishbone master command port.
//  Revision    : 1.0  initial release
// ============================================================================
package wb_dma_pkg;

   // Sequencer states: one read then one write per word, each with an
   // issue cycle followed by the two-phase active handshake.
   typedef enum logic [2:0] {
      S_IDLE         = 3'd0,
      S_RD_ISSUE     = 3'd1,
      S_RD_WAIT_ACT  = 3'd2,
      S_RD_WAIT_DONE = 3'd3,
      S_WR_ISSUE     = 3'd4,
      S_WR_WAIT_ACT  = 3'd5,
      S_WR_WAIT_DONE = 3'd6,
      S_FINISH       = 3'd7
   } dma_state_t;

   // Byte-address step between consecutive 32-bit words.
   localparam int WORD_INCR = 4;

   // All four byte lanes enabled for whole-word transfers.
   localparam logic [3:0] SEL_WORD = 4'hF;

endpackage : wb_dma_pkg
`default_nettype wire

// File: rtl/wb_dma_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : wb_dma_timeout
//  Description : Loadable down-counter guarding one handshake phase. Reloads
//                on i_load and flags expiry once TIMEOUT cycles have passed
//                without a reload.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_dma_timeout #(
   parameter int TIMEOUT = 64
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_load,
   output logic o_expired
);

   localparam int              CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] c_load = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] r_cnt;

   // Reload on phase entry, otherwise count down and park at zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= c_load;
      end else if (i_load) begin
         r_cnt <= c_load;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_expired = (r_cnt == '0);

endmodule : wb_dma_timeout
`default_nettype wire

// File: rtl/wb_dma_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : wb_dma_sequencer
//  Description : Word-copy engine in front of wb_master_interface. Copies a
//                block of 32-bit words, one read then one write per word,
//                with per-phase timeout and end-of-word abort.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_dma_sequencer
   import wb_dma_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int CW      = 16,
   parameter int TIMEOUT = 64
) (
   input  logic          wb_clk,
   input  logic          wb_rst_n,
   input  logic          go,
   input  logic          abort,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [CW-1:0] word_count,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [CW-1:0] words_done,
   output logic          start,
   output logic [AW-1:0] address,
   output logic [3:0]    selection,
   output logic          write,
   output logic [DW-1:0] data_wr,
   input  logic [DW-1:0] data_rd,
   input  logic          active
);

   dma_state_t    r_state;
   dma_state_t    w_state_nxt;

   logic [AW-1:0] r_src_ptr;
   logic [AW-1:0] r_dst_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_words_done;
   logic [DW-1:0] r_hold;
   logic          r_abort;
   logic          r_to_flag;
   logic          r_busy;
   logic          r_done;
   logic          r_error;
   logic [AW-1:0] r_addr_last;
   logic [DW-1:0] r_data_last;
   logic          r_write_last;

   logic          w_go_accept;
   logic          w_wr_complete;
   logic          w_timeout;
   logic          w_timer_load;
   logic          w_timer_expired;

   assign w_go_accept  = (r_state == S_IDLE) && go;
   // Any state change reloads the timer, so each WAIT state starts fresh.
   assign w_timer_load = (w_state_nxt != r_state);

   wb_dma_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .i_clk     (wb_clk),
      .i_rst_n   (wb_rst_n),
      .i_load    (w_timer_load),
      .o_expired (w_timer_expired)
   );

   // State register.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a handshake edge wins over a same-cycle expiry.
   always_comb begin
      w_state_nxt   = r_state;
      w_wr_complete = 1'b0;
      w_timeout     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (go) begin
               w_state_nxt = (word_count == '0) ? S_FINISH : S_RD_ISSUE;
            end
         end
         S_RD_ISSUE: w_state_nxt = S_RD_WAIT_ACT;
         S_RD_WAIT_ACT: begin
            if (active) begin
               w_state_nxt = S_RD_WAIT_DONE;
            end else if (w_timer_expired) begin
               w_state_nxt = S_FINISH;
               w_timeout   = 1'b1;
            end
         end
         S_RD_WAIT_DONE: begin
            if (!active) begin
               w_state_nxt = S_WR_ISSUE;
            end else if (w_timer_expired) begin
               w_state_nxt = S_FINISH;
               w_timeout   = 1'b1;
            end
         end
         S_WR_ISSUE: w_state_nxt = S_WR_WAIT_ACT;
         S_WR_WAIT_ACT: begin
            if (active) begin
               w_state_nxt = S_WR_WAIT_DONE;
            end else if (w_timer_expired) begin
               w_state_nxt = S_FINISH;
               w_timeout   = 1'b1;
            end
         end
         S_WR_WAIT_DONE: begin
            if (!active) begin
               w_wr_complete = 1'b1;
               if ((r_words_done + CW'(1) == r_count) || r_abort || abort) begin
                  w_state_nxt = S_FINISH;
               end else begin
                  w_state_nxt = S_RD_ISSUE;
               end
            end else if (w_timer_expired) begin
               w_state_nxt = S_FINISH;
               w_timeout   = 1'b1;
            end
         end
         S_FINISH: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Copy context: latched arguments, pointers, progress, abort and timeout flags.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_src_ptr    <= '0;
         r_dst_ptr    <= '0;
         r_count      <= '0;
         r_words_done <= '0;
         r_hold       <= '0;
         r_abort      <= 1'b0;
         r_to_flag    <= 1'b0;
      end else if (w_go_accept) begin
         r_src_ptr    <= src_addr;
         r_dst_ptr    <= dst_addr;
         r_count      <= word_count;
         r_words_done <= '0;
         r_abort      <= 1'b0;
         r_to_flag    <= 1'b0;
      end else begin
         if (r_state != S_IDLE) begin
            r_abort <= r_abort | abort;
         end
         if ((r_state == S_RD_WAIT_DONE) && !active) begin
            r_hold <= data_rd;
         end
         if (w_wr_complete) begin
            r_words_done <= r_words_done + CW'(1);
            r_src_ptr    <= r_src_ptr + AW'(WORD_INCR);
            r_dst_ptr    <= r_dst_ptr + AW'(WORD_INCR);
         end
         if (w_timeout) begin
            r_to_flag <= 1'b1;
         end else if (r_state == S_FINISH) begin
            r_to_flag <= 1'b0;
         end
      end
   end

   // Status outputs: done/error trail the FINISH state by one cycle, busy drops with them.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else begin
         if (w_go_accept) begin
            r_busy <= 1'b1;
         end else if (r_state == S_FINISH) begin
            r_busy <= 1'b0;
         end
         r_done  <= (r_state == S_FINISH);
         r_error <= (r_state == S_FINISH) && r_to_flag;
      end
   end

   // Remember the last command so it holds between issue cycles.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_addr_last  <= '0;
         r_data_last  <= '0;
         r_write_last <= 1'b0;
      end else begin
         r_addr_last  <= address;
         r_data_last  <= data_wr;
         r_write_last <= write;
      end
   end

   // Command port: new values only in the issue cycles, held otherwise.
   always_comb begin
      start   = 1'b0;
      address = r_addr_last;
      data_wr = r_data_last;
      write   = r_write_last;
      if (r_state == S_RD_ISSUE) begin
         start   = 1'b1;
         write   = 1'b0;
         address = r_src_ptr;
      end else if (r_state == S_WR_ISSUE) begin
         start   = 1'b1;
         write   = 1'b1;
         address = r_dst_ptr;
         data_wr = r_hold;
      end
   end

   assign selection  = SEL_WORD;
   assign busy       = r_busy;
   assign done       = r_done;
   assign error      = r_error;
   assign words_done = r_words_done;

endmodule : wb_dma_sequencer
`default_nettype wire

// File: tb/tb_wb_dma_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_wb_dma_sequencer
//  Description : Self-checking bench: a bus-slave memory model answers the
//                command port, and each copy is checked against a word-by-word
//                copy done on a shadow memory.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_dma_sequencer;

   localparam int AW = 32, DW = 32, CW = 16, TIMEOUT = 64;

   logic          wb_clk = 1'b0, wb_rst_n = 1'b0, go = 1'b0, abort = 1'b0;
   logic [AW-1:0] src_addr = '0, dst_addr = '0;
   logic [CW-1:0] word_count = '0;
   logic          busy, done, error, start, write;
   logic [CW-1:0] words_done;
   logic [AW-1:0] address;
   logic [3:0]    selection;
   logic [DW-1:0] data_wr;
   logic [DW-1:0] data_rd = '0;
   logic          active = 1'b0;

   always #5 wb_clk = ~wb_clk;

   wb_dma_sequencer #(.AW(AW), .DW(DW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
      .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .go(go), .abort(abort),
      .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
      .busy(busy), .done(done), .error(error), .words_done(words_done),
      .start(start), .address(address), .selection(selection), .write(write),
      .data_wr(data_wr), .data_rd(data_rd), .active(active)
   );

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      int          cnt;
      int          mode;       // 0 plain, 1 abort after first write issued, 2 go while busy
      bit          stall;      // slave never raises active
      int          exp_words;
      bit          exp_err;
      int          exp_lat_go;    // go-to-done cycles, -1 = not checked
      int          exp_lat_start; // first start-to-done cycles, -1 = not checked
      int          exp_busy;      // busy cycles, -1 = not checked
   } vec_t;

   int n_vec = 0, n_err = 0, cyc = 0, go_cyc = 0;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] mm  [logic [31:0]];

   // slave model state
   bit          m_busy = 0, m_stall = 0;
   int          m_phase = 0, m_wait = 0, lat_max = 3;
   logic [31:0] m_addr = '0, m_data = '0;
   logic        m_we = 1'b0, prev_start = 1'b0;

   // per-copy observations
   int          o_starts, o_dones, o_busy_cyc, o_first_start, o_done_cyc;
   bit          o_seen_done;
   logic        o_err;
   logic [CW-1:0] o_words;

   function automatic logic [31:0] rd_mem(logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'h5A5A_A5A5;
   endfunction

   function automatic logic [31:0] rd_mm(logic [31:0] a);
      if (mm.exists(a)) return mm[a];
      return a ^ 32'h5A5A_A5A5;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic reset_slave();
      m_busy = 0; m_phase = 0; active = 1'b0; prev_start = 1'b0;
   endtask

   // One clock: observe outputs just after the edge, then advance the slave.
   task automatic tick();
      @(posedge wb_clk);
      #1;
      cyc++;
      if (start) begin
         o_starts++;
         if (o_first_start < 0) o_first_start = cyc;
         check("selection", {60'd0, selection}, 64'hF);
         check("start_gap", {63'd0, prev_start}, 64'd0);
      end
      prev_start = start;
      if (busy) o_busy_cyc++;
      if (done) begin
         o_dones++;
         if (!o_seen_done) begin
            o_seen_done = 1; o_done_cyc = cyc; o_err = error; o_words = words_done;
         end
      end
      data_rd = $urandom;
      if (m_busy) begin
         if (m_phase == 0) begin
            if (!m_stall) begin
               if (m_wait <= 1) begin
                  active = 1'b1; m_phase = 1; m_wait = $urandom_range(1, lat_max);
               end else m_wait--;
            end
         end else if (m_wait <= 1) begin
            active = 1'b0; m_busy = 0;
            if (m_we) mem[m_addr] = m_data;
            else      data_rd = rd_mem(m_addr);
         end else m_wait--;
      end else if (start) begin
         m_busy = 1; m_phase = 0; m_addr = address; m_we = write; m_data = data_wr;
         m_wait = $urandom_range(1, lat_max);
      end
   endtask

   task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                           input int mode, input bit stall);
      o_starts = 0; o_dones = 0; o_busy_cyc = 0; o_first_start = -1;
      o_seen_done = 0; o_err = 1'b0; o_words = '0; o_done_cyc = 0;
      reset_slave();
      m_stall = stall;
      src_addr = s; dst_addr = d; word_count = CW'(n); go = 1'b1; go_cyc = cyc;
      tick();
      go = 1'b0; src_addr = $urandom; dst_addr = $urandom; word_count = CW'($urandom);
      for (int k = 0; k < 4000 && !o_seen_done; k++) begin
         if (mode == 1 && o_starts >= 2) abort = 1'b1;
         if (mode == 2 && k == 3) begin
            go = 1'b1; src_addr = 32'h6000_0000; dst_addr = 32'h3600_0000; word_count = 16'd5;
         end else go = 1'b0;
         tick();
      end
      abort = 1'b0; go = 1'b0;
      repeat (4) tick();
   endtask

   task automatic do_vec(input vec_t v);
      mm = mem;
      for (int i = 0; i < v.exp_words; i++)
         mm[v.dst + 32'(4*i)] = rd_mm(v.src + 32'(4*i));
      run_copy(v.src, v.dst, v.cnt, v.mode, v.stall);
      check("done_seen", {63'd0, o_seen_done}, 64'd1);
      check("done_pulses", 64'(o_dones), 64'd1);
      check("error", {63'd0, o_err}, {63'd0, v.exp_err});
      check("words_done", {48'd0, o_words}, 64'(v.exp_words));
      check("start_count", 64'(o_starts), v.stall ? 64'd1 : 64'(2 * v.exp_words));
      check("busy_after", {63'd0, busy}, 64'd0);
      for (int i = 0; i <= v.cnt && i < 9; i++)
         check("dst_word", {32'd0, rd_mem(v.dst + 32'(4*i))}, {32'd0, rd_mm(v.dst + 32'(4*i))});
      if (v.exp_lat_go >= 0)    check("go_to_done", 64'(o_done_cyc - go_cyc), 64'(v.exp_lat_go));
      if (v.exp_lat_start >= 0) check("start_to_done", 64'(o_done_cyc - o_first_start), 64'(v.exp_lat_start));
      if (v.exp_busy >= 0)      check("busy_cycles", 64'(o_busy_cyc), 64'(v.exp_busy));
      if (v.mode == 2)
         check("ignored_go_dst", {32'd0, rd_mem(32'h3600_0000)}, {32'd0, rd_mm(32'h3600_0000)});
   endtask

   vec_t vecs [7];
   vec_t rv;

   initial begin
      vecs[0] = '{32'h2000_0000, 32'h3000_0000, 4, 0, 0, 4, 0, -1, -1, -1};
      vecs[1] = '{32'h2000_0000, 32'h3100_0000, 0, 0, 0, 0, 0,  2, -1,  1};
      vecs[2] = '{32'h2000_0000, 32'h3200_0000, 8, 1, 0, 1, 0, -1, -1, -1};
      vecs[3] = '{32'h2000_0000, 32'h3300_0000, 3, 0, 1, 0, 1, -1, TIMEOUT + 2, -1};
      vecs[4] = '{32'hFFFF_FFF8, 32'h4000_0000, 4, 0, 0, 4, 0, -1, -1, -1};
      vecs[5] = '{32'h4000_0000, 32'h5000_0000, 1, 0, 0, 1, 0, -1, -1, -1};
      vecs[6] = '{32'h2000_0000, 32'h3400_0000, 3, 2, 0, 3, 0, -1, -1, -1};

      for (int i = 0; i < 4; i++) mem[32'h2000_0000 + 32'(4*i)] = 32'h1111_1111 * (i + 1);

      // reset values
      wb_rst_n = 1'b0;
      repeat (3) tick();
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_error", {63'd0, error}, 64'd0);
      check("rst_start", {63'd0, start}, 64'd0);
      check("rst_write", {63'd0, write}, 64'd0);
      check("rst_words", {48'd0, words_done}, 64'd0);
      check("rst_address", {32'd0, address}, 64'd0);
      check("rst_data_wr", {32'd0, data_wr}, 64'd0);
      check("rst_selection", {60'd0, selection}, 64'hF);
      wb_rst_n = 1'b1;
      tick();

      // table-driven copies
      for (int i = 0; i < 7; i++) begin
         do_vec(vecs[i]);
         if (i == 0)
            for (int w = 0; w < 4; w++)
               check("ram1_word", {32'd0, rd_mem(32'h3000_0000 + 32'(4*w))}, {32'd0, 32'h1111_1111 * (w + 1)});
      end

      // reset in the middle of a copy
      reset_slave(); m_stall = 0; o_starts = 0; o_first_start = -1; o_seen_done = 0;
      src_addr = 32'h2000_0000; dst_addr = 32'h3500_0000; word_count = 16'd4; go = 1'b1;
      tick();
      go = 1'b0;
      for (int k = 0; k < 200 && o_starts < 3; k++) tick();
      check("midcopy_reached", 64'(o_starts >= 3), 64'd1);
      wb_rst_n = 1'b0;
      #1;
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_start", {63'd0, start}, 64'd0);
      check("midrst_write", {63'd0, write}, 64'd0);
      check("midrst_done", {63'd0, done}, 64'd0);
      check("midrst_words", {48'd0, words_done}, 64'd0);
      check("midrst_address", {32'd0, address}, 64'd0);
      check("midrst_data_wr", {32'd0, data_wr}, 64'd0);
      reset_slave();
      tick();
      wb_rst_n = 1'b1;
      reset_slave();
      tick();
      rv = '{32'h2000_0000, 32'h9000_0000, 2, 0, 0, 2, 0, -1, -1, -1};
      do_vec(rv);

      // randomized copies against the shadow-memory model
      for (int r = 0; r < 20; r++) begin
         int n;
         n = $urandom_range(0, 6);
         lat_max = $urandom_range(1, 4);
         rv.src = 32'h2000_0000 + 32'($urandom_range(0, 3)) * 32'h0100_0000 + 32'(4 * $urandom_range(0, 8));
         rv.dst = 32'h2000_0000 + 32'($urandom_range(0, 3)) * 32'h0100_0000 + 32'(4 * $urandom_range(0, 8));
         rv.cnt = n; rv.mode = 0; rv.stall = 0; rv.exp_words = n; rv.exp_err = 0;
         rv.exp_lat_go = (n == 0) ? 2 : -1; rv.exp_lat_start = -1; rv.exp_busy = -1;
         do_vec(rv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_wb_dma_sequencer
`default_nettype wire
